// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: counter sizing and lane-mask generation.
package axis_pkg;

  // Widest keep mask that axis_keep_lane can produce.
  localparam int AXIS_MAX_LANES = 64;

  // Width of a lane counter covering 0..ratio-1; never narrower than one bit.
  function automatic int axis_cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // One-hot mask with only lane idx set.
  function automatic logic [AXIS_MAX_LANES-1:0] axis_keep_lane(input int idx);
    return AXIS_MAX_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/axis_width_upsizer_if.sv
// Bundle of the narrow input stream and the wide packed output stream.
// slave  : view of the upsizer itself (consumes s_axis_*, produces m_axis_*).
// master : view of the surrounding logic (feeds s_axis_*, sinks m_axis_*).
interface axis_width_upsizer_if #(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4
);
  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;

  logic [S_DATA_WIDTH-1:0] s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;

  logic [M_DATA_WIDTH-1:0] m_axis_tdata;
  logic [RATIO-1:0]        m_axis_tkeep;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow beats into one wide word, little-endian by lane, with
// tkeep marking filled lanes. tlast closes a word early; a partial word keeps
// zeros in its unwritten lanes. One accumulator stage feeds one output register.
module axis_width_upsizer
  import axis_pkg::*;
#(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_width_upsizer_if.slave  bus
);

  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int CNT_W        = axis_cnt_width(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // Stage p0: accumulator being filled lane by lane.
  logic [CNT_W-1:0]        cnt_p0;
  logic [M_DATA_WIDTH-1:0] acc_data_p0;
  logic [RATIO-1:0]        acc_keep_p0;

  // Stage p1: output register presented on m_axis_*.
  logic [M_DATA_WIDTH-1:0] data_p1;
  logic [RATIO-1:0]        keep_p1;
  logic                    last_p1;
  logic                    vld_p1;

  logic                      accept;
  logic                      complete;
  logic [M_DATA_WIDTH-1:0]   acc_data_nxt;
  logic [RATIO-1:0]          acc_keep_nxt;
  logic [AXIS_MAX_LANES-1:0] lane_mask;

  // Input is taken whenever the output register is empty or draining this cycle.
  assign bus.s_axis_tready = !vld_p1 || bus.m_axis_tready;
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  assign complete          = accept && ((cnt_p0 == CNT_LAST) || bus.s_axis_tlast);

  // Merge the incoming beat into the current accumulator lane.
  always_comb begin
    acc_data_nxt = acc_data_p0;
    acc_keep_nxt = acc_keep_p0;
    lane_mask    = axis_keep_lane(int'(cnt_p0));
    acc_data_nxt[int'(cnt_p0)*S_DATA_WIDTH +: S_DATA_WIDTH] = bus.s_axis_tdata;
    acc_keep_nxt = acc_keep_p0 | lane_mask[RATIO-1:0];
  end

  // Accumulator and lane counter; cleared whenever a word is handed to p1.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_p0      <= '0;
      acc_data_p0 <= '0;
      acc_keep_p0 <= '0;
    end else if (accept) begin
      if (complete) begin
        cnt_p0      <= '0;
        acc_data_p0 <= '0;
        acc_keep_p0 <= '0;
      end else begin
        cnt_p0      <= cnt_p0 + CNT_W'(1);
        acc_data_p0 <= acc_data_nxt;
        acc_keep_p0 <= acc_keep_nxt;
      end
    end
  end

  // Output register: loads on completion, holds while stalled, drops valid once drained.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (complete) begin
      data_p1 <= acc_data_nxt;
      keep_p1 <= acc_keep_nxt;
      last_p1 <= bus.s_axis_tlast;
      vld_p1  <= 1'b1;
    end else if (bus.m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.m_axis_tdata  = data_p1;
  assign bus.m_axis_tkeep  = keep_p1;
  assign bus.m_axis_tlast  = last_p1;
  assign bus.m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed bench for axis_width_upsizer: a RATIO=4 instance and a RATIO=1 instance.
module tb_axis_width_upsizer;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  axis_width_upsizer_if #(.S_DATA_WIDTH(8), .RATIO(4)) bus4 ();
  axis_width_upsizer_if #(.S_DATA_WIDTH(8), .RATIO(1)) bus1 ();

  axis_width_upsizer #(.S_DATA_WIDTH(8), .RATIO(4)) dut4 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus4)
  );

  axis_width_upsizer #(.S_DATA_WIDTH(8), .RATIO(1)) dut1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send4(input logic [7:0] d, input logic l);
    bus4.s_axis_tvalid = 1'b1;
    bus4.s_axis_tdata  = d;
    bus4.s_axis_tlast  = l;
    tick();
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    bus1.s_axis_tvalid = 1'b1;
    bus1.s_axis_tdata  = d;
    bus1.s_axis_tlast  = l;
    tick();
  endtask

  task automatic idle4();
    bus4.s_axis_tvalid = 1'b0;
    bus4.s_axis_tlast  = 1'b0;
    tick();
  endtask

  task automatic check_word4(input string tag, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    check({tag, "_valid"}, 32'(bus4.m_axis_tvalid), 32'd1);
    check({tag, "_data"},  bus4.m_axis_tdata,       d);
    check({tag, "_keep"},  32'(bus4.m_axis_tkeep),  32'(k));
    check({tag, "_last"},  32'(bus4.m_axis_tlast),  32'(l));
  endtask

  initial begin
    int words;
    checks = 0;
    errors = 0;
    aresetn = 1'b0;
    bus4.s_axis_tvalid = 1'b0;
    bus4.s_axis_tdata  = '0;
    bus4.s_axis_tlast  = 1'b0;
    bus4.m_axis_tready = 1'b1;
    bus1.s_axis_tvalid = 1'b0;
    bus1.s_axis_tdata  = '0;
    bus1.s_axis_tlast  = 1'b0;
    bus1.m_axis_tready = 1'b1;
    tick();
    tick();

    check("rst_valid",  32'(bus4.m_axis_tvalid), 32'd0);
    check("rst_keep",   32'(bus4.m_axis_tkeep),  32'd0);
    check("rst_data",   bus4.m_axis_tdata,       32'd0);
    check("rst_last",   32'(bus4.m_axis_tlast),  32'd0);
    check("rst_sready", 32'(bus4.s_axis_tready), 32'd1);
    aresetn = 1'b1;

    // Full four-lane frame
    send4(8'h01, 1'b0);
    check("t1_b1_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h02, 1'b0);
    send4(8'h03, 1'b0);
    check("t1_b3_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h04, 1'b1);
    check_word4("t1", 32'h04030201, 4'b1111, 1'b1);
    idle4();
    check("t1_drain", 32'(bus4.m_axis_tvalid), 32'd0);

    // Short frame, then a single-beat frame landing in lane 0 back to back
    send4(8'hAA, 1'b0);
    send4(8'hBB, 1'b0);
    send4(8'hCC, 1'b1);
    check_word4("t2", 32'h00CCBBAA, 4'b0111, 1'b1);
    send4(8'hDD, 1'b1);
    check_word4("t2_lane0", 32'h000000DD, 4'b0001, 1'b1);
    idle4();
    check("t2_drain", 32'(bus4.m_axis_tvalid), 32'd0);

    // Back-pressure across an eight-beat frame
    send4(8'h10, 1'b0);
    send4(8'h11, 1'b0);
    send4(8'h12, 1'b0);
    send4(8'h13, 1'b0);
    check_word4("t3_w0", 32'h13121110, 4'b1111, 1'b0);
    bus4.m_axis_tready = 1'b0;
    bus4.s_axis_tvalid = 1'b1;
    bus4.s_axis_tdata  = 8'h14;
    bus4.s_axis_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_stall_sready", 32'(bus4.s_axis_tready), 32'd0);
      check("t3_stall_valid",  32'(bus4.m_axis_tvalid), 32'd1);
      check("t3_stall_data",   bus4.m_axis_tdata,       32'h13121110);
      tick();
    end
    bus4.m_axis_tready = 1'b1;
    #1;
    check("t3_release_sready", 32'(bus4.s_axis_tready), 32'd1);
    tick();
    check("t3_after14_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h15, 1'b0);
    send4(8'h16, 1'b0);
    check("t3_after16_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h17, 1'b1);
    check_word4("t3_w1", 32'h17161514, 4'b1111, 1'b1);
    idle4();

    // 64 back-to-back beats at full rate
    words = 0;
    for (int k = 0; k < 64; k++) begin
      send4(8'(k + 8'h40), (k == 63) ? 1'b1 : 1'b0);
      check("t4_sready", 32'(bus4.s_axis_tready), 32'd1);
      if ((k % 4) == 3) begin
        words++;
        check("t4_valid", 32'(bus4.m_axis_tvalid), 32'd1);
        check("t4_data", bus4.m_axis_tdata,
              {8'(k + 8'h40), 8'(k + 8'h3F), 8'(k + 8'h3E), 8'(k + 8'h3D)});
      end else begin
        check("t4_gap_valid", 32'(bus4.m_axis_tvalid), 32'd0);
      end
    end
    check("t4_words", 32'(words), 32'd16);
    check("t4_last", 32'(bus4.m_axis_tlast), 32'd1);
    idle4();

    // Reset in the middle of a word discards it
    send4(8'h21, 1'b0);
    send4(8'h22, 1'b0);
    bus4.s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    tick();
    check("t5_rst_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    check("t5_rst_keep",  32'(bus4.m_axis_tkeep),  32'd0);
    check("t5_rst_data",  bus4.m_axis_tdata,       32'd0);
    check("t5_rst_last",  32'(bus4.m_axis_tlast),  32'd0);
    aresetn = 1'b1;
    send4(8'h55, 1'b0);
    send4(8'h66, 1'b0);
    check("t5_b2_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h77, 1'b0);
    check("t5_b3_valid", 32'(bus4.m_axis_tvalid), 32'd0);
    send4(8'h88, 1'b0);
    check_word4("t5", 32'h88776655, 4'b1111, 1'b0);
    idle4();

    // RATIO=1: every beat is a word
    check("t6_idle_valid", 32'(bus1.m_axis_tvalid), 32'd0);
    send1(8'h5A, 1'b0);
    check("t6_w0_valid", 32'(bus1.m_axis_tvalid), 32'd1);
    check("t6_w0_data",  32'(bus1.m_axis_tdata),  32'h5A);
    check("t6_w0_keep",  32'(bus1.m_axis_tkeep),  32'd1);
    check("t6_w0_last",  32'(bus1.m_axis_tlast),  32'd0);
    send1(8'h5B, 1'b1);
    check("t6_w1_valid", 32'(bus1.m_axis_tvalid), 32'd1);
    check("t6_w1_data",  32'(bus1.m_axis_tdata),  32'h5B);
    check("t6_w1_keep",  32'(bus1.m_axis_tkeep),  32'd1);
    check("t6_w1_last",  32'(bus1.m_axis_tlast),  32'd1);
    bus1.s_axis_tvalid = 1'b0;
    tick();
    check("t6_drain", 32'(bus1.m_axis_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
